// File: rtl/reg_bank.sv
// Multi-port register bank: one write, one increment and one clear per cycle,
// two combinational read ports, a per-register zero mask and an increment-wrap pulse.
module reg_bank #(
  parameter int                WIDTH     = 12,
  parameter int                DEPTH     = 4,
  parameter logic [WIDTH-1:0]  RESET_VAL = '0,
  localparam int               ADDR_W    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wrEn,
  input  logic [ADDR_W-1:0] wrAddr,
  input  logic [WIDTH-1:0]  dataIn,
  input  logic              incEn,
  input  logic [ADDR_W-1:0] incAddr,
  input  logic              clrEn,
  input  logic [ADDR_W-1:0] clrAddr,
  input  logic [ADDR_W-1:0] rdAddrA,
  output logic [WIDTH-1:0]  dataOutA,
  input  logic [ADDR_W-1:0] rdAddrB,
  output logic [WIDTH-1:0]  dataOutB,
  output logic              incWrap,
  output logic [DEPTH-1:0]  zeroMask
);

  logic [DEPTH-1:0][WIDTH-1:0] regs_flat;
  logic [DEPTH-1:0]            wrap_vec;
  logic                        inc_wrap_q, inc_wrap_d;

  // Each register decodes its own hits; an address >= DEPTH never matches any
  // register, so out-of-range operations are dropped naturally.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_reg
    logic             wr_hit, inc_hit, clr_hit;
    logic [WIDTH-1:0] val_q, val_d;

    assign wr_hit  = wrEn  && (wrAddr  == ADDR_W'(gi));
    assign inc_hit = incEn && (incAddr == ADDR_W'(gi));
    assign clr_hit = clrEn && (clrAddr == ADDR_W'(gi));

    always_comb begin
      val_d = val_q;
      if (clr_hit) begin
        val_d = RESET_VAL;
      end else if (wr_hit) begin
        val_d = dataIn;
      end else if (inc_hit) begin
        val_d = val_q + WIDTH'(1);
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        val_q <= RESET_VAL;
      end else begin
        val_q <= val_d;
      end
    end

    // Wrap only counts when the increment is the operation that actually lands.
    assign wrap_vec[gi]  = inc_hit && !clr_hit && !wr_hit && (&val_q);
    assign regs_flat[gi] = val_q;
    assign zeroMask[gi]  = (val_q == '0);
  end

  assign inc_wrap_d = |wrap_vec;

  always_ff @(posedge clk) begin
    if (rst) begin
      inc_wrap_q <= 1'b0;
    end else begin
      inc_wrap_q <= inc_wrap_d;
    end
  end

  assign incWrap = inc_wrap_q;

  always_comb begin
    dataOutA = '0;
    dataOutB = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (rdAddrA == ADDR_W'(i)) dataOutA = regs_flat[i];
      if (rdAddrB == ADDR_W'(i)) dataOutB = regs_flat[i];
    end
  end

endmodule

// File: tb/tb_reg_bank.sv
// Directed and random checks of reg_bank against a small reference model,
// with expected outputs queued at drive time and compared after each edge.
module tb_reg_bank;

  localparam int WIDTH = 12;
  localparam int DEPTH = 4;
  localparam int AW    = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic             wrEn, incEn, clrEn;
  logic [AW-1:0]    wrAddr, incAddr, clrAddr, rdAddrA, rdAddrB;
  logic [WIDTH-1:0] dataIn, dataOutA, dataOutB;
  logic             incWrap;
  logic [DEPTH-1:0] zeroMask;

  reg_bank #(.WIDTH(WIDTH), .DEPTH(DEPTH), .RESET_VAL('0)) dut (
    .clk(clk), .rst(rst),
    .wrEn(wrEn), .wrAddr(wrAddr), .dataIn(dataIn),
    .incEn(incEn), .incAddr(incAddr),
    .clrEn(clrEn), .clrAddr(clrAddr),
    .rdAddrA(rdAddrA), .dataOutA(dataOutA),
    .rdAddrB(rdAddrB), .dataOutB(dataOutB),
    .incWrap(incWrap), .zeroMask(zeroMask)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [DEPTH-1:0] mask;
    logic             wrap;
  } exp_t;

  exp_t             exp_q[$];
  string            tag_q[$];
  logic [WIDTH-1:0] model [DEPTH];
  int               n_vec  = 0;
  int               n_fail = 0;

  task automatic chk(input string tag, input string what,
                     input logic [WIDTH-1:0] got, input logic [WIDTH-1:0] want);
    n_vec++;
    assert (got === want) else begin
      n_fail++;
      $error("FAIL %s %s got %h want %h", tag, what, got, want);
    end
  endtask

  // Drive one cycle at the falling edge, update the model to its post-edge
  // state, queue the expectation and compare it after the rising edge.
  task automatic step(input string tag, input logic r,
                      input logic we, input logic [AW-1:0] wa, input logic [WIDTH-1:0] d,
                      input logic ie, input logic [AW-1:0] ia,
                      input logic ce, input logic [AW-1:0] ca,
                      input logic [AW-1:0] ra, input logic [AW-1:0] rb);
    exp_t             e;
    logic [WIDTH-1:0] nxt [DEPTH];
    logic             wrap;
    @(negedge clk);
    rst = r; wrEn = we; wrAddr = wa; dataIn = d; incEn = ie; incAddr = ia;
    clrEn = ce; clrAddr = ca; rdAddrA = ra; rdAddrB = rb;
    for (int i = 0; i < DEPTH; i++) nxt[i] = model[i];
    wrap = 1'b0;
    if (r) begin
      for (int i = 0; i < DEPTH; i++) nxt[i] = '0;
    end else begin
      if (ie && !(ce && ca == ia) && !(we && wa == ia)) begin
        wrap    = (model[ia] == 12'hFFF);
        nxt[ia] = model[ia] + 12'd1;
      end
      if (we) nxt[wa] = d;
      if (ce) nxt[ca] = '0;
    end
    for (int i = 0; i < DEPTH; i++) model[i] = nxt[i];
    e.a    = model[ra];
    e.b    = model[rb];
    for (int i = 0; i < DEPTH; i++) e.mask[i] = (model[i] == '0);
    e.wrap = wrap;
    exp_q.push_back(e);
    tag_q.push_back(tag);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      chk(tag, "queue", 12'd0, 12'd1);
    end else begin
      string t;
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      chk(t, "dataOutA", dataOutA, e.a);
      chk(t, "dataOutB", dataOutB, e.b);
      chk(t, "zeroMask", {8'd0, zeroMask}, {8'd0, e.mask});
      chk(t, "incWrap", {11'd0, incWrap}, {11'd0, e.wrap});
    end
  endtask

  task automatic idle(input string tag, input logic [AW-1:0] ra, input logic [AW-1:0] rb);
    step(tag, 1'b0, 1'b0, 2'd0, 12'd0, 1'b0, 2'd0, 1'b0, 2'd0, ra, rb);
  endtask

  task automatic wr(input string tag, input logic [AW-1:0] a, input logic [WIDTH-1:0] d);
    step(tag, 1'b0, 1'b1, a, d, 1'b0, 2'd0, 1'b0, 2'd0, a, a);
  endtask

  initial begin
    rst = 1'b1; wrEn = 0; incEn = 0; clrEn = 0;
    wrAddr = 0; incAddr = 0; clrAddr = 0; dataIn = 0; rdAddrA = 0; rdAddrB = 0;
    for (int i = 0; i < DEPTH; i++) model[i] = 'x;

    // Reset state, then the two-write / dual-read scenario.
    step("reset", 1'b1, 1'b0, 2'd0, 12'd0, 1'b0, 2'd0, 1'b0, 2'd0, 2'd0, 2'd3);
    idle("reset_hold", 2'd1, 2'd2);
    wr("wr_r1_20", 2'd1, 12'd20);
    step("wr_r2_43", 1'b0, 1'b1, 2'd2, 12'd43, 1'b0, 2'd0, 1'b0, 2'd0, 2'd1, 2'd2);
    idle("same_addr_read", 2'd2, 2'd2);

    // Increment through all-ones with a single-cycle wrap pulse.
    wr("wr_r0_ffe", 2'd0, 12'hFFE);
    step("inc_r0_fff", 1'b0, 1'b0, 2'd0, 12'd0, 1'b1, 2'd0, 1'b0, 2'd0, 2'd0, 2'd1);
    step("inc_r0_wrap", 1'b0, 1'b0, 2'd0, 12'd0, 1'b1, 2'd0, 1'b0, 2'd0, 2'd0, 2'd1);
    idle("wrap_drops", 2'd0, 2'd1);

    // Same-address priority: clear > write > increment, no wrap when suppressed.
    wr("wr_r3_5", 2'd3, 12'd5);
    step("clr_wr_inc_r3", 1'b0, 1'b1, 2'd3, 12'd7, 1'b1, 2'd3, 1'b1, 2'd3, 2'd3, 2'd0);
    step("wr_inc_r3", 1'b0, 1'b1, 2'd3, 12'd9, 1'b1, 2'd3, 1'b0, 2'd0, 2'd3, 2'd0);
    wr("wr_r3_fff", 2'd3, 12'hFFF);
    step("wr_beats_inc_wrap", 1'b0, 1'b1, 2'd3, 12'd1, 1'b1, 2'd3, 1'b0, 2'd0, 2'd3, 2'd0);
    wr("wr_r3_fff_b", 2'd3, 12'hFFF);
    step("clr_beats_inc_wrap", 1'b0, 1'b0, 2'd0, 12'd0, 1'b1, 2'd3, 1'b1, 2'd3, 2'd3, 2'd0);

    // Independent operations on distinct addresses in one cycle.
    wr("wr_r1_5", 2'd1, 12'd5);
    wr("wr_r2_8", 2'd2, 12'd8);
    step("wr0_inc1_clr2", 1'b0, 1'b1, 2'd0, 12'd100, 1'b1, 2'd1, 1'b1, 2'd2, 2'd0, 2'd1);
    idle("check_r2_r3", 2'd2, 2'd3);

    // Reset overrides concurrent write and wrapping increment.
    wr("wr_r1_fff", 2'd1, 12'hFFF);
    step("rst_over_ops", 1'b1, 1'b1, 2'd1, 12'd55, 1'b1, 2'd1, 1'b0, 2'd0, 2'd1, 2'd0);
    idle("after_rst_23", 2'd2, 2'd3);
    wr("wr_r2_77", 2'd2, 12'd77);

    // A reset pulse that starts and ends between edges must not touch state.
    @(negedge clk);
    rdAddrA = 2'd2; rdAddrB = 2'd2;
    rst = 1'b1;
    #2;
    rst = 1'b0;
    #1;
    chk("rst_glitch", "dataOutA", dataOutA, 12'd77);
    chk("rst_glitch", "zeroMask", {8'd0, zeroMask}, {8'd0, 4'b1011});
    idle("rst_glitch_edge", 2'd2, 2'd1);

    // Random traffic against the model.
    for (int n = 0; n < 1000; n++) begin
      step("random", ($urandom_range(19) == 0),
           1'($urandom), 2'($urandom), ($urandom_range(3) == 0) ? 12'hFFF : 12'($urandom),
           1'($urandom), 2'($urandom),
           ($urandom_range(3) == 0), 2'($urandom),
           2'($urandom), 2'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
